// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle CPU: sequences fetch, decode, execute, memory and writeback.
// Outputs are combinational from state/opcode/zero/mem_ready; the memory states hold until mem_ready.
module multicycle_ctrl #(
  parameter logic [3:0] RST_PC_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_op,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [3:0] S_IF = 4'd0, S_ID = 4'd1, S_MADDR = 4'd2, S_MRD = 4'd3,
                         S_MWB = 4'd4, S_MWR = 4'd5, S_REX = 4'd6, S_RWB = 4'd7,
                         S_BR = 4'd8, S_JMP = 4'd9, S_IEX = 4'd10, S_IWB = 4'd11;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ORI = 6'h0D,
                         OP_LW = 6'h23, OP_SW = 6'h2B;

  logic [3:0] state_q;
  logic [3:0] next_state;
  logic       funct_unused;

  // funct is decoded by the ALU control, not here
  assign funct_unused = ^funct;
  assign state        = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RST_PC_STATE;
    else        state_q <= next_state;
  end

  always_comb begin
    next_state = S_IF;
    case (state_q)
      S_IF:    next_state = mem_ready ? S_ID : S_IF;
      S_ID: begin
        case (opcode)
          OP_R:            next_state = S_REX;
          OP_LW, OP_SW:    next_state = S_MADDR;
          OP_BEQ, OP_BNE:  next_state = S_BR;
          OP_J, OP_JAL:    next_state = S_JMP;
          OP_ADDI, OP_ORI: next_state = S_IEX;
          default:         next_state = S_IF;
        endcase
      end
      S_MADDR: next_state = (opcode == OP_SW) ? S_MWR : S_MRD;
      S_MRD:   next_state = mem_ready ? S_MWB : S_MRD;
      S_MWR:   next_state = mem_ready ? S_IF : S_MWR;
      S_REX:   next_state = S_RWB;
      S_IEX:   next_state = S_IWB;
      default: next_state = S_IF;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    ext_op     = 1'b0;
    alu_op     = 2'd0;
    pc_source  = 2'd0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_IF: begin
          mem_read  = 1'b1;
          alu_src_b = 2'd1;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_ID: begin
          alu_src_b = 2'd3;
          ext_op    = 1'b1;
          case (opcode)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_ADDI, OP_ORI: ;
            default: begin
              illegal    = 1'b1;
              instr_done = 1'b1;
            end
          endcase
        end
        S_MADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          ext_op    = 1'b1;
        end
        S_MRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'd1;
          instr_done = 1'b1;
        end
        S_MWR: begin
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
        end
        S_REX: begin
          alu_src_a = 1'b1;
          alu_op    = 2'd2;
        end
        S_RWB: begin
          reg_write  = 1'b1;
          reg_dst    = 2'd1;
          instr_done = 1'b1;
        end
        S_BR: begin
          alu_src_a  = 1'b1;
          alu_op     = 2'd1;
          pc_source  = 2'd1;
          instr_done = 1'b1;
          pc_write   = (opcode == OP_BNE) ? ~zero : zero;
        end
        S_JMP: begin
          // jal links the already-incremented PC on the same edge the PC jumps
          pc_write   = 1'b1;
          pc_source  = 2'd2;
          instr_done = 1'b1;
          if (opcode == OP_JAL) begin
            reg_write  = 1'b1;
            reg_dst    = 2'd2;
            mem_to_reg = 2'd2;
          end
        end
        S_IEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          ext_op    = (opcode != OP_ORI);
          alu_op    = (opcode == OP_ORI) ? 2'd3 : 2'd0;
        end
        S_IWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: vector table, hand sequences and randomized instruction stream
// checked against a phase-list model of each instruction.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_write, iord, mem_read, mem_write, ir_write, reg_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
  logic       alu_src_a, ext_op, instr_done, illegal;
  logic [3:0] state;

  multicycle_ctrl #(.RST_PC_STATE(4'd0)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_op(ext_op), .alu_op(alu_op), .pc_source(pc_source),
    .state(state), .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [19:0] outs;
  assign outs = {pc_write, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
                 mem_to_reg, alu_src_a, alu_src_b, ext_op, alu_op, pc_source,
                 instr_done, illegal};

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Outputs captured by run_instr
  int done_at, iex_ext, iex_aluop;
  int fin_state, fin_pcw, fin_pcs, fin_rw, fin_rd, fin_mtr, fin_mw, fin_ill;

  // Build the phase list an instruction should walk through, drive it and check each cycle.
  task automatic run_instr(input logic [5:0] op, input logic z, input int w_if, input int w_mem);
    int q[$];
    bit r[$];
    int n_pcw = 0, n_rw = 0, n_irw = 0, n_mw = 0, n_ill = 0;
    int exp_pcw, exp_rw;
    for (int k = 0; k < w_if; k++) begin q.push_back(0); r.push_back(1'b0); end
    q.push_back(0); r.push_back(1'b1);
    q.push_back(1); r.push_back(1'($urandom));
    case (op)
      6'h00: begin q.push_back(6); q.push_back(7); end
      6'h23: begin
        q.push_back(2);
        for (int k = 0; k < w_mem; k++) q.push_back(3);
        q.push_back(3); q.push_back(4);
      end
      6'h2B: begin
        q.push_back(2);
        for (int k = 0; k <= w_mem; k++) q.push_back(5);
      end
      6'h04, 6'h05: q.push_back(8);
      6'h02, 6'h03: q.push_back(9);
      6'h08, 6'h0D: begin q.push_back(10); q.push_back(11); end
      default: ;
    endcase
    // mem_ready plan for the remaining phases: waits are 0, final cycle of a memory phase is 1
    for (int i = r.size(); i < q.size(); i++) begin
      if (q[i] == 3 || q[i] == 5)
        r.push_back((i == q.size() - 1 || q[i + 1] != q[i]) ? 1'b1 : 1'b0);
      else
        r.push_back(1'($urandom));
    end
    done_at = -1; iex_ext = -1; iex_aluop = -1;
    for (int i = 0; i < q.size(); i++) begin
      opcode = op; funct = 6'($urandom); zero = z; mem_ready = r[i];
      #2;
      chk("state", int'(state), q[i]);
      chk("instr_done", int'(instr_done), int'(i == q.size() - 1));
      chk("mem_read", int'(mem_read), int'(q[i] == 0 || q[i] == 3));
      chk("ir_write", int'(ir_write), int'(q[i] == 0 && r[i]));
      if (instr_done && done_at < 0) done_at = i;
      if (state == 4'd10) begin iex_ext = int'(ext_op); iex_aluop = int'(alu_op); end
      n_pcw += int'(pc_write); n_rw += int'(reg_write); n_irw += int'(ir_write);
      n_mw += int'(mem_write); n_ill += int'(illegal);
      if (i == q.size() - 1) begin
        fin_state = int'(state); fin_pcw = int'(pc_write); fin_pcs = int'(pc_source);
        fin_rw = int'(reg_write); fin_rd = int'(reg_dst); fin_mtr = int'(mem_to_reg);
        fin_mw = int'(mem_write); fin_ill = int'(illegal);
      end
      @(posedge clk); #1;
    end
    exp_pcw = 1 + int'((op == 6'h04 && z) || (op == 6'h05 && !z) || op == 6'h02 || op == 6'h03);
    exp_rw  = int'(op == 6'h00 || op == 6'h23 || op == 6'h03 || op == 6'h08 || op == 6'h0D);
    chk("pc_write_count", n_pcw, exp_pcw);
    chk("reg_write_count", n_rw, exp_rw);
    chk("ir_write_count", n_irw, 1);
    chk("mem_write_cycles", n_mw, (op == 6'h2B) ? w_mem + 1 : 0);
    chk("illegal_count", n_ill, (q.size() == w_if + 2) ? 1 : 0);
  endtask

  typedef struct {
    logic [5:0] op;
    logic       z;
    int cycles, st, pcw, pcs, rw, rd, mtr, mw, ill;
  } vec_t;

  vec_t tbl[12];
  logic [5:0] legal_ops[10];

  initial begin
    tbl[0]  = '{6'h00, 1'b0, 4,  7, 0, 0, 1, 1, 0, 0, 0};
    tbl[1]  = '{6'h23, 1'b0, 5,  4, 0, 0, 1, 0, 1, 0, 0};
    tbl[2]  = '{6'h2B, 1'b0, 4,  5, 0, 0, 0, 0, 0, 1, 0};
    tbl[3]  = '{6'h04, 1'b1, 3,  8, 1, 1, 0, 0, 0, 0, 0};
    tbl[4]  = '{6'h04, 1'b0, 3,  8, 0, 1, 0, 0, 0, 0, 0};
    tbl[5]  = '{6'h05, 1'b0, 3,  8, 1, 1, 0, 0, 0, 0, 0};
    tbl[6]  = '{6'h05, 1'b1, 3,  8, 0, 1, 0, 0, 0, 0, 0};
    tbl[7]  = '{6'h02, 1'b0, 3,  9, 1, 2, 0, 0, 0, 0, 0};
    tbl[8]  = '{6'h03, 1'b0, 3,  9, 1, 2, 1, 2, 2, 0, 0};
    tbl[9]  = '{6'h08, 1'b0, 4, 11, 0, 0, 1, 0, 0, 0, 0};
    tbl[10] = '{6'h0D, 1'b1, 4, 11, 0, 0, 1, 0, 0, 0, 0};
    tbl[11] = '{6'h3F, 1'b0, 2,  1, 0, 0, 0, 0, 0, 0, 1};
    legal_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08, 6'h0D, 6'h00};

    rst_n = 1'b0; opcode = 6'h0; funct = 6'h0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    #2;
    chk("reset_state", int'(state), 0);
    chk("reset_outputs", int'(outs), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].z, 0, 0);
      chk("tbl_latency", done_at + 1, tbl[i].cycles);
      chk("tbl_state", fin_state, tbl[i].st);
      chk("tbl_pc_write", fin_pcw, tbl[i].pcw);
      chk("tbl_pc_source", fin_pcs, tbl[i].pcs);
      chk("tbl_reg_write", fin_rw, tbl[i].rw);
      chk("tbl_reg_dst", fin_rd, tbl[i].rd);
      chk("tbl_mem_to_reg", fin_mtr, tbl[i].mtr);
      chk("tbl_mem_write", fin_mw, tbl[i].mw);
      chk("tbl_illegal", fin_ill, tbl[i].ill);
    end

    // ori vs addi immediate handling in the execute phase
    run_instr(6'h0D, 1'b0, 0, 0);
    chk("ori_ext_op", iex_ext, 0);
    chk("ori_alu_op", iex_aluop, 3);
    run_instr(6'h08, 1'b0, 0, 0);
    chk("addi_ext_op", iex_ext, 1);
    chk("addi_alu_op", iex_aluop, 0);

    // lw with 2 fetch waits and 3 read waits
    run_instr(6'h23, 1'b0, 2, 3);
    chk("lw_wait_latency", done_at + 1, 10);

    // reset asserted while holding in the memory-read phase
    opcode = 6'h23; zero = 1'b0;
    mem_ready = 1'b1; @(posedge clk); #1;
    mem_ready = 1'b0; @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    chk("pre_reset_mrd_state", int'(state), 3);
    rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    chk("reset_mrd_outputs", int'(outs), 0);
    @(posedge clk); #1;
    chk("reset_mrd_next_state", int'(state), 0);
    rst_n = 1'b1;

    // randomized instruction stream with random wait states
    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 5) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 8)];
      run_instr(op, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
